// File: rtl/enc_pkg.sv
// ---------------------------------------------------------------------------
// enc_pkg
// Shared types and constants for the encoder pass controller.
//   enc_state_e  : controller FSM states
//   len_t        : word length in symbols (0 .. 2**PKG_ADDR_WIDTH inclusive)
//   SRAM_RD_LAT  : read latency of the input/output SRAMs, in cycles
// ---------------------------------------------------------------------------
package enc_pkg;

  localparam int unsigned PKG_ADDR_WIDTH = 4;

  // One extra bit so a full 2**PKG_ADDR_WIDTH word length is representable.
  typedef logic [PKG_ADDR_WIDTH:0] len_t;

  localparam int unsigned SRAM_RD_LAT = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GRP_START = 3'd1,
    ST_GRP_WAIT  = 3'd2,
    ST_CHECK     = 3'd3,
    ST_COPY      = 3'd4,
    ST_DRAIN     = 3'd5,
    ST_FINISH    = 3'd6
  } enc_state_e;

endpackage : enc_pkg

// File: rtl/ram_copy_engine.sv
// ---------------------------------------------------------------------------
// ram_copy_engine
// Streams output_ram[0..len-1] into input_ram[0..len-1]. One read address is
// issued per cycle; the matching write is issued SRAM_RD_LAT cycles later,
// when the read data is valid on output_ram.dout.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : 1-cycle launch; len is captured with it
//   len       : number of words to copy
//   raddr     : output_ram read address (holds at len-1 once reading ends)
//   waddr     : input_ram write address (raddr delayed by the read latency)
//   we        : input_ram write enable
//   rd_last   : final read address is being issued this cycle
//   last      : final write is being issued this cycle
// ---------------------------------------------------------------------------
module ram_copy_engine
  import enc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  we,
  output logic                  rd_last,
  output logic                  last
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);

  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   rcnt_q;
  logic [ADDR_WIDTH:0]   rcnt_inc;
  logic                  rd_act_q;
  logic [SRAM_RD_LAT-1:0] we_pipe_q;
  logic [SRAM_RD_LAT-1:0] last_pipe_q;
  logic [ADDR_WIDTH-1:0] waddr_pipe_q [SRAM_RD_LAT];

  // The counter is one bit wider than the address so the comparison against
  // a full-depth length never wraps. A zero length still ends after one read
  // rather than hanging the sequencer.
  assign rcnt_inc = rcnt_q + CNT_ONE;
  assign rd_last  = rd_act_q && (rcnt_inc >= len_q);

  assign raddr = rcnt_q[ADDR_WIDTH-1:0];
  assign waddr = waddr_pipe_q[SRAM_RD_LAT-1];
  assign we    = we_pipe_q[SRAM_RD_LAT-1];
  assign last  = last_pipe_q[SRAM_RD_LAT-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q       <= '0;
      rcnt_q      <= '0;
      rd_act_q    <= 1'b0;
      we_pipe_q   <= '0;
      last_pipe_q <= '0;
      // NOTE: this address pipe is only SRAM_RD_LAT entries deep, so it is
      // reset like ordinary flops; a real storage array would not be.
      for (int i = 0; i < SRAM_RD_LAT; i++) begin
        waddr_pipe_q[i] <= '0;
      end
    end else begin
      if (start) begin
        len_q    <= len;
        rcnt_q   <= '0;
        rd_act_q <= 1'b1;
      end else if (rd_act_q) begin
        if (rd_last) begin
          rd_act_q <= 1'b0;
        end else begin
          rcnt_q <= rcnt_inc;
        end
      end

      // Write side trails the read side by the SRAM read latency.
      we_pipe_q[0]    <= rd_act_q;
      last_pipe_q[0]  <= rd_last;
      waddr_pipe_q[0] <= rcnt_q[ADDR_WIDTH-1:0];
      for (int i = 1; i < SRAM_RD_LAT; i++) begin
        we_pipe_q[i]    <= we_pipe_q[i-1];
        last_pipe_q[i]  <= last_pipe_q[i-1];
        waddr_pipe_q[i] <= waddr_pipe_q[i-1];
      end
    end
  end

endmodule : ram_copy_engine

// File: rtl/encoder_pass_ctrl.sv
// ---------------------------------------------------------------------------
// encoder_pass_ctrl
// Sequences the grouper over repeated merge passes. Each pass that merges is
// followed by a copy of output_ram back into input_ram; the run ends when a
// pass merges nothing or MAX_PASSES passes have merged, and done pulses.
// Optional build macro:
//   ENC_CTRL_TIMEOUT_EN : watchdog on GRP_WAIT; after TIMEOUT_CYCLES without
//                         grp_done the run ends with err=1. Undefined: err=0
//                         and GRP_WAIT waits indefinitely.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start, len   : run request (accepted only in IDLE) and word length
//   busy, done   : run in progress / 1-cycle completion pulse
//   limit_hit    : with done, pass limit reached while still merging
//   err          : with done, grouper timeout
//   pass_cnt     : completed passes, held until the next start
//   grp_start    : launch one grouper pass
//   grp_done, grp_merged, grp_len : grouper pass result
//   copy_own     : controller owns the SRAM address/we muxes
//   copy_raddr, copy_waddr, copy_we : copy-phase SRAM controls
// ---------------------------------------------------------------------------
module encoder_pass_ctrl
  import enc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned MAX_PASSES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [ADDR_WIDTH:0]               len,
  output logic                              busy,
  output logic                              done,
  output logic                              limit_hit,
  output logic                              err,
  output logic [$clog2(MAX_PASSES+1)-1:0]   pass_cnt,
  output logic                              grp_start,
  input  logic                              grp_done,
  input  logic                              grp_merged,
  input  logic [ADDR_WIDTH:0]               grp_len,
  output logic                              copy_own,
  output logic [ADDR_WIDTH-1:0]             copy_raddr,
  output logic [ADDR_WIDTH-1:0]             copy_waddr,
  output logic                              copy_we
);

  localparam int unsigned         CNT_W   = $clog2(MAX_PASSES + 1);
  localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(MAX_PASSES);
  localparam logic [ADDR_WIDTH:0] LEN_TWO = (ADDR_WIDTH + 1)'(2);

  enc_state_e          state_q, state_d;
  logic [ADDR_WIDTH:0] len_q;
  logic [CNT_W-1:0]    pass_cnt_q;
  logic                merged_q;
  logic                limit_q;
  logic                eng_start;
  logic                eng_rd_last;
  logic                eng_last;
  logic                wd_expire;

  // DATA_WIDTH sizes the external copy data path only; nothing here inspects
  // data. TIMEOUT_CYCLES matters only in watchdog builds.
  logic unused_cfg;
  assign unused_cfg = (DATA_WIDTH == 0) | (TIMEOUT_CYCLES == 0);

  // -------------------------------------------------------------------------
  // Grouper watchdog
  // -------------------------------------------------------------------------
`ifdef ENC_CTRL_TIMEOUT_EN
  localparam int unsigned      WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q;
  logic            err_q;

  // Expiry fires on the last permitted GRP_WAIT cycle; a grp_done in that
  // same cycle still wins.
  assign wd_expire = (state_q == ST_GRP_WAIT) && !grp_done && (wd_q == WD_LAST);
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= (state_q == ST_GRP_WAIT) ? wd_q + WD_ONE : '0;
      if ((state_q == ST_IDLE) && start) begin
        err_q <= 1'b0;
      end else if (wd_expire) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign wd_expire = 1'b0;
  assign err       = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next-state and state-decoded outputs
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would infer a latch.
    state_d   = state_q;
    eng_start = 1'b0;
    busy      = (state_q != ST_IDLE);
    done      = 1'b0;
    grp_start = 1'b0;
    copy_own  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          // A word shorter than two symbols cannot merge; finish immediately.
          state_d = (len < LEN_TWO) ? ST_FINISH : ST_GRP_START;
        end
      end
      ST_GRP_START: begin
        grp_start = 1'b1;
        state_d   = ST_GRP_WAIT;
      end
      ST_GRP_WAIT: begin
        if (grp_done) begin
          state_d = ST_CHECK;
        end else if (wd_expire) begin
          state_d = ST_FINISH;
        end
      end
      ST_CHECK: begin
        // No merge means input_ram already holds the final word.
        if (merged_q) begin
          eng_start = 1'b1;
          state_d   = ST_COPY;
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_COPY: begin
        copy_own = 1'b1;
        if (eng_rd_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        copy_own = 1'b1;
        if (eng_last) begin
          state_d = limit_q ? ST_FINISH : ST_GRP_START;
        end
      end
      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State, length, pass counter and result flags
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      pass_cnt_q <= '0;
      merged_q   <= 1'b0;
      limit_q    <= 1'b0;
    end else begin
      state_q <= state_d;

      if ((state_q == ST_IDLE) && start) begin
        len_q      <= len;
        pass_cnt_q <= '0;
        limit_q    <= 1'b0;
      end

      if ((state_q == ST_GRP_WAIT) && grp_done) begin
        merged_q   <= grp_merged;
        pass_cnt_q <= pass_cnt_q + CNT_ONE;
        if (grp_merged) begin
          len_q <= grp_len;
        end
      end

      // The limiting pass still gets its copy; DRAIN then ends the run.
      if ((state_q == ST_CHECK) && merged_q && (pass_cnt_q == CNT_MAX)) begin
        limit_q <= 1'b1;
      end
    end
  end

  assign pass_cnt  = pass_cnt_q;
  assign limit_hit = limit_q;

  // -------------------------------------------------------------------------
  // Copy datapath: output_ram -> input_ram
  // -------------------------------------------------------------------------
  ram_copy_engine #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_copy (
    .clk     (clk),
    .rst     (rst),
    .start   (eng_start),
    .len     (len_q),
    .raddr   (copy_raddr),
    .waddr   (copy_waddr),
    .we      (copy_we),
    .rd_last (eng_rd_last),
    .last    (eng_last)
  );

endmodule : encoder_pass_ctrl

// File: tb/tb_encoder_pass_ctrl.sv
// ---------------------------------------------------------------------------
// tb_encoder_pass_ctrl
// Scoreboard bench: stimulus pushes expected done results and expected copy
// address sequences; a negedge monitor pops and compares whenever the DUT
// presents done, copy_own or copy_we. The instance uses MAX_PASSES=3 so a
// three-pass run that stops merging exercises the limit boundary without
// hitting it, and an always-merging run hits it on pass three.
// ---------------------------------------------------------------------------
module tb_encoder_pass_ctrl;

  localparam int AW   = 4;
  localparam int DW   = 8;
  localparam int MAXP = 3;
  localparam int TMO  = 10;
  localparam int CW   = $clog2(MAXP + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic          limit_hit;
  logic          err;
  logic [CW-1:0] pass_cnt;
  logic          grp_start;
  logic          grp_done;
  logic          grp_merged;
  logic [AW:0]   grp_len;
  logic          copy_own;
  logic [AW-1:0] copy_raddr;
  logic [AW-1:0] copy_waddr;
  logic          copy_we;

  always #5 clk = ~clk;

  encoder_pass_ctrl #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .MAX_PASSES     (MAXP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .limit_hit  (limit_hit),
    .err        (err),
    .pass_cnt   (pass_cnt),
    .grp_start  (grp_start),
    .grp_done   (grp_done),
    .grp_merged (grp_merged),
    .grp_len    (grp_len),
    .copy_own   (copy_own),
    .copy_raddr (copy_raddr),
    .copy_waddr (copy_waddr),
    .copy_we    (copy_we)
  );

  typedef struct packed {
    logic [CW-1:0] pass_cnt;
    logic          limit_hit;
    logic          err;
  } done_exp_t;

  done_exp_t     exp_done_q[$];
  logic [AW-1:0] exp_rd_q[$];
  logic [AW-1:0] exp_wr_q[$];

  int n_checks      = 0;
  int n_errors      = 0;
  int grp_start_cnt = 0;

  done_exp_t     mon_done;
  logic [AW-1:0] mon_addr;
  bit            seen;
  bit            got;
  int            cycles;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic done_exp_t mk_done(input int pc, input bit lh, input bit er);
    done_exp_t d;
    d.pass_cnt  = CW'(pc);
    d.limit_hit = lh;
    d.err       = er;
    return d;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (grp_start) grp_start_cnt++;

      if (done) begin
        if (exp_done_q.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          mon_done = exp_done_q.pop_front();
          check("done_pass_cnt",  pass_cnt,  mon_done.pass_cnt);
          check("done_limit_hit", limit_hit, mon_done.limit_hit);
          check("done_err",       err,       mon_done.err);
        end
      end

      if (copy_own) begin
        if (exp_rd_q.size() == 0) begin
          check("unexpected_copy_own", copy_own, 0);
        end else begin
          mon_addr = exp_rd_q.pop_front();
          check("copy_raddr", copy_raddr, mon_addr);
        end
      end

      if (copy_we) begin
        check("copy_we_owned", copy_own, 1);
        if (exp_wr_q.size() == 0) begin
          check("unexpected_copy_we", copy_we, 0);
        end else begin
          mon_addr = exp_wr_q.pop_front();
          check("copy_waddr", copy_waddr, mon_addr);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int l);
    start = 1'b1;
    len   = (AW + 1)'(l);
    tick();
    start = 1'b0;
  endtask

  // A copy of l words: l+1 owned cycles reading 0..l-1 then holding l-1,
  // and l writes to 0..l-1.
  task automatic push_copy(input int l);
    for (int i = 0; i < l; i++) exp_rd_q.push_back(AW'(i));
    exp_rd_q.push_back(AW'(l - 1));
    for (int i = 0; i < l; i++) exp_wr_q.push_back(AW'(i));
  endtask

  task automatic wait_grp_start(output bit s);
    s = 1'b0;
    for (int i = 0; i < 200 && !s; i++) begin
      @(negedge clk);
      if (grp_start) s = 1'b1;
    end
    check("grp_start_seen", s, 1);
  endtask

  task automatic run_pass(input bit merged, input int glen);
    bit s;
    wait_grp_start(s);
    if (s) begin
      tick();
      tick();
      tick();
      grp_done   = 1'b1;
      grp_merged = merged;
      grp_len    = (AW + 1)'(glen);
      if (merged) push_copy(glen);
      tick();
      grp_done   = 1'b0;
      grp_merged = 1'b0;
      grp_len    = '0;
    end
  endtask

  task automatic wait_done(input string name);
    bit s = 1'b0;
    for (int i = 0; i < 300 && !s; i++) begin
      @(negedge clk);
      if (done) s = 1'b1;
    end
    check(name, s, 1);
    tick();
  endtask

  task automatic poke_start_busy();
    start = 1'b1;
    len   = (AW + 1)'(1);
    @(negedge clk);
    check("busy_during_run", busy, 1);
    tick();
    start = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst = 1'b1; start = 1'b0; len = '0;
    grp_done = 1'b0; grp_merged = 1'b0; grp_len = '0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_outputs",
          {busy, done, limit_hit, err, pass_cnt, grp_start, copy_own, copy_raddr, copy_waddr, copy_we}, 0);
    tick();
    rst = 1'b0;
    tick();

    // len=5: merges at 4 and 3 symbols, third pass stops merging.
    grp_start_cnt = 0;
    exp_done_q.push_back(mk_done(3, 1'b0, 1'b0));
    do_start(5);
    run_pass(1'b1, 4);
    poke_start_busy();
    run_pass(1'b1, 3);
    run_pass(1'b0, 3);
    wait_done("t1_done_seen");
    check("t1_grp_starts", grp_start_cnt, 3);
    check("t1_idle_after_done", busy, 0);

    // Always merging: limit reached on pass 3, three copies, no fourth pass.
    grp_start_cnt = 0;
    exp_done_q.push_back(mk_done(3, 1'b1, 1'b0));
    do_start(8);
    run_pass(1'b1, 8);
    run_pass(1'b1, 7);
    run_pass(1'b1, 6);
    wait_done("t2_done_seen");
    repeat (4) tick();
    check("t2_grp_starts", grp_start_cnt, 3);

    // len=1: no grouper pass, done one cycle after start.
    grp_start_cnt = 0;
    exp_done_q.push_back(mk_done(0, 1'b0, 1'b0));
    do_start(1);
    @(negedge clk);
    check("t3_done_latency", done, 1);
    tick();
    check("t3_grp_starts", grp_start_cnt, 0);

    // Full-depth word: 16 writes, addresses must not wrap.
    grp_start_cnt = 0;
    exp_done_q.push_back(mk_done(2, 1'b0, 1'b0));
    do_start(16);
    run_pass(1'b1, 16);
    run_pass(1'b0, 16);
    wait_done("t4_done_seen");
    check("t4_grp_starts", grp_start_cnt, 2);

    // Reset during COPY: everything clears, no done, next run is normal.
    do_start(6);
    run_pass(1'b1, 6);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_rd_q.delete();
    exp_wr_q.delete();
    @(negedge clk);
    check("t5_outputs_after_rst",
          {busy, done, limit_hit, err, pass_cnt, grp_start, copy_own, copy_raddr, copy_waddr, copy_we}, 0);
    repeat (6) tick();
    grp_start_cnt = 0;
    exp_done_q.push_back(mk_done(2, 1'b0, 1'b0));
    do_start(3);
    run_pass(1'b1, 2);
    run_pass(1'b0, 2);
    wait_done("t5_rerun_done_seen");
    check("t5_grp_starts", grp_start_cnt, 2);

`ifdef ENC_CTRL_TIMEOUT_EN
    // Grouper never answers: done with err after TMO cycles of GRP_WAIT;
    // a start while busy and a late grp_done in IDLE are both ignored.
    grp_start_cnt = 0;
    exp_done_q.push_back(mk_done(0, 1'b0, 1'b1));
    do_start(4);
    wait_grp_start(seen);
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (cycles == 3) begin start = 1'b1; len = (AW + 1)'(5); end
      if (cycles == 4) start = 1'b0;
      if (done) got = 1'b1;
    end
    check("t6_timeout_done_seen", got, 1);
    check("t6_timeout_latency", cycles, TMO + 1);
    tick();
    grp_done = 1'b1; grp_merged = 1'b1; grp_len = (AW + 1)'(3);
    tick();
    grp_done = 1'b0; grp_merged = 1'b0; grp_len = '0;
    @(negedge clk);
    check("t6_late_grp_done_ignored", busy, 0);
    repeat (4) tick();
    check("t6_grp_starts", grp_start_cnt, 1);
`endif

    repeat (4) tick();
    check("left_exp_done", exp_done_q.size(), 0);
    check("left_exp_rd",   exp_rd_q.size(),   0);
    check("left_exp_wr",   exp_wr_q.size(),   0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule : tb_encoder_pass_ctrl
